store_router: RTL
=================

// Module: store_router
// PURPOSE
//  Write-side counterpart of the load/fetch return path. Decodes EX-stage store
//  requests by address region and generates aligned write data plus byte enables.
//  Writes go to DMEM or IMEM through registered strobes, or to a small MMIO write
//  FIFO with a valid/ready drain. Misaligned stores, illegal stores and BIOS
//  stores are dropped and flagged.
// PARAMETERS
//  IO_FIFO_DEPTH  4  MMIO write FIFO entries; power of two, >= 2
//  MEM_AW         14 DMEM/IMEM word-address width, taken from st_addr[MEM_AW+1:2]
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous, active-low reset
//  st_valid       in   1       store request this cycle
//  st_addr        in   32      byte address
//  st_data        in   32      unaligned rs2 value
//  st_funct3      in   3       000 SB, 001 SH, 010 SW; others illegal
//  pc30           in   1       1 = executing from BIOS; enables IMEM writes
//  st_stall       out  1       combinational; request not accepted this cycle
//  dmem_we        out  4       DMEM byte enables (registered)
//  dmem_addr      out  MEM_AW  DMEM word address (registered)
//  dmem_din       out  32      DMEM aligned write data (registered)
//  imem_we        out  4       IMEM byte enables (registered)
//  imem_addr      out  MEM_AW  IMEM word address (registered)
//  imem_din       out  32      IMEM aligned write data (registered)
//  io_valid       out  1       FIFO head valid
//  io_ready       in   1       MMIO consumer accepts head
//  io_addr        out  8       head st_addr[7:0], word-aligned
//  io_be          out  4       head byte enables
//  io_data        out  32      head aligned data
//  st_fault       out  1       1-cycle pulse, registered: request dropped
//  err_count      out  16      dropped-store count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all registered outputs 0; FIFO empty (io_valid=0, pointers/count 0).
//  - Alignment:
//     SB: be = 4'b0001 << a[1:0]; data = {4{d[7:0]}}.
//     SH: a[0] must be 0; be = 4'b0011 << a[1:0]; data = {2{d[15:0]}}.
//     SW: a[1:0] must be 0; be = 4'hF; data = d.
//  - Region decode, st_addr[31:28]:
//     0001 DMEM
//     0011 DMEM and IMEM (IMEM half only if pc30=1)
//     0010 IMEM (only if pc30=1)
//     1000 MMIO FIFO
//     anything else, including 0100 BIOS: dropped
//  - Drop cases: misaligned, illegal funct3, BIOS/unmapped region, IMEM-only store
//    with pc30=0. A dropped store asserts st_fault the next cycle and gives no
//    we/FIFO push. 0011 with pc30=0 writes DMEM only and is not a fault.
//  - Memory latency: accepted store in cycle N -> *_we/addr/din valid in cycle N+1
//    for exactly one cycle. *_we is 0 every other cycle; addr/din hold last value.
//  - FIFO push: accepted MMIO store. Pop: io_valid & io_ready. Head on io_*.
//  - Full: st_stall = st_valid & region==1000 & full. No push. Pop in the same cycle
//    does not bypass, so stall holds that cycle and the store is retried.
//  - Push and pop in the same non-full, non-empty cycle: count unchanged, order kept.
//  - Empty: io_valid=0; io_ready ignored. No fall-through: push in N -> io_valid in N+1.
//  - Pointers wrap modulo IO_FIFO_DEPTH. Count is $clog2(DEPTH)+1 bits.
//  - st_stall never asserts for non-MMIO regions.
//  - Reset mid-operation clears FIFO contents and any pending strobe immediately.
// CONFIGURATION
//  STORE_ERR_CNT_EN defined: err_count increments on each st_fault pulse and
//    saturates at 16'hFFFF; cleared only by reset.
//  Undefined: no counter logic; err_count tied to 16'h0000.
// TESTING
//  - SB, addr 0x1000_0007, data 0xAB -> next cycle dmem_we=1000, dmem_addr=0x001,
//    dmem_din=0xABABABAB, imem_we=0.
//  - SW, addr 0x3000_0010, pc30=1 -> dmem_we=imem_we=1111, both addr=0x004.
//    Same store with pc30=0 -> dmem only, st_fault=0.
//  - SH, addr 0x1000_0003 -> no strobes; st_fault pulse; err_count=1 with
//    STORE_ERR_CNT_EN, 0 without.
//  - 5 SW to 0x8000_0008 with io_ready=0, DEPTH=4 -> 4 pushes, st_stall on the 5th.
//    Raise io_ready -> entries drain in order, stall drops next cycle.
//  - Push+pop same cycle at count=2 -> count stays 2.
//    rst low mid-burst -> io_valid=0 at once, FIFO empty.

Source files
------------

// File: rtl/store_router_if.sv
// store_router_if: store request, memory write strobes, MMIO drain and fault status
interface store_router_if #(parameter int MEM_AW = 14);
  logic              st_valid;
  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic [2:0]        st_funct3;
  logic              pc30;
  logic              st_stall;
  logic [3:0]        dmem_we;
  logic [MEM_AW-1:0] dmem_addr;
  logic [31:0]       dmem_din;
  logic [3:0]        imem_we;
  logic [MEM_AW-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              io_valid;
  logic              io_ready;
  logic [7:0]        io_addr;
  logic [3:0]        io_be;
  logic [31:0]       io_data;
  logic              st_fault;
  logic [15:0]       err_count;
  modport master (
    output st_valid, st_addr, st_data, st_funct3, pc30, io_ready,
    input  st_stall, dmem_we, dmem_addr, dmem_din, imem_we, imem_addr, imem_din,
           io_valid, io_addr, io_be, io_data, st_fault, err_count
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, pc30, io_ready,
    output st_stall, dmem_we, dmem_addr, dmem_din, imem_we, imem_addr, imem_din,
           io_valid, io_addr, io_be, io_data, st_fault, err_count
  );
endinterface

// File: rtl/store_router.sv
// store_router: decodes stores into DMEM/IMEM strobes or an MMIO write FIFO.
// Define STORE_ERR_CNT_EN to enable the saturating dropped-store counter.
module store_router #(
  parameter int IO_FIFO_DEPTH = 4,
  parameter int MEM_AW        = 14
) (
  input logic         clk,
  input logic         rst,
  store_router_if.slave bus
);
  localparam int PW = $clog2(IO_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(IO_FIFO_DEPTH);
  logic [3:0]  region;
  logic [1:0]  a;
  logic [2:0]  f3;
  logic        aligned, dmem_hit, imem_hit, io_hit, mapped;
  logic        accept, wr, fault, push, pop, full;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [3:0]  q_be   [IO_FIFO_DEPTH];
  logic [7:0]  q_addr [IO_FIFO_DEPTH];
  logic [31:0] q_data [IO_FIFO_DEPTH];
  logic        unused_addr;
  assign region   = bus.st_addr[31:28];
  assign a        = bus.st_addr[1:0];
  assign f3       = bus.st_funct3;
  assign aligned  = (f3 == 3'b000) | (f3 == 3'b001 & ~a[0]) | (f3 == 3'b010 & a == 2'b00);
  assign be       = f3 == 3'b000 ? 4'b0001 << a : f3 == 3'b001 ? 4'b0011 << a : 4'hF;
  assign wdata    = f3 == 3'b000 ? {4{bus.st_data[7:0]}} :
                    f3 == 3'b001 ? {2{bus.st_data[15:0]}} : bus.st_data;
  assign dmem_hit = region == 4'h1 | region == 4'h3;
  assign imem_hit = (region == 4'h2 | region == 4'h3) & bus.pc30;
  assign io_hit   = region == 4'h8;
  assign mapped   = dmem_hit | imem_hit | io_hit;
  assign full     = cnt == FULL_CNT;
  assign bus.st_stall = bus.st_valid & io_hit & full;
  assign accept   = bus.st_valid & ~bus.st_stall;
  assign wr       = accept & aligned & mapped;
  assign fault    = accept & ~(aligned & mapped);
  assign push     = wr & io_hit;
  assign pop      = bus.io_valid & bus.io_ready;
  assign bus.io_valid = cnt != '0;
  assign bus.io_be    = q_be[rp];
  assign bus.io_addr  = q_addr[rp];
  assign bus.io_data  = q_data[rp];
  assign unused_addr  = ^bus.st_addr[27:MEM_AW+2];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dmem_we   <= '0;
      bus.dmem_addr <= '0;
      bus.dmem_din  <= '0;
      bus.imem_we   <= '0;
      bus.imem_addr <= '0;
      bus.imem_din  <= '0;
      bus.st_fault  <= 1'b0;
    end else begin
      bus.dmem_we  <= wr & dmem_hit ? be : 4'h0;
      bus.imem_we  <= wr & imem_hit ? be : 4'h0;
      bus.st_fault <= fault;
      if (wr & dmem_hit) begin
        bus.dmem_addr <= bus.st_addr[MEM_AW+1:2];
        bus.dmem_din  <= wdata;
      end
      if (wr & imem_hit) begin
        bus.imem_addr <= bus.st_addr[MEM_AW+1:2];
        bus.imem_din  <= wdata;
      end
    end
  end
  // Stall guarantees push never happens while full, so no overflow guard is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < IO_FIFO_DEPTH; i++) begin
        q_be[i]   <= '0;
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_be[wp]   <= be;
        q_addr[wp] <= {bus.st_addr[7:2], 2'b00};
        q_data[wp] <= wdata;
        wp         <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
`ifdef STORE_ERR_CNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else if (fault && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end
  assign bus.err_count = err_q;
`else
  assign bus.err_count = 16'h0000;
`endif
endmodule
